// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module : regfile_pkg
// Brief  : Shared defaults and helpers for the multiport register file.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
// Contents:
//   DEFAULT_DATA_W   - default register width
//   DEFAULT_NREGS    - default register count (power of two)
//   DEFAULT_NRD      - default number of read ports
//   DEFAULT_LINK_REG - default trap return-address register index
//   clog2()          - ceiling log2 for constant width calculation
// ============================================================================
package regfile_pkg;

  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_NREGS    = 32;
  localparam int DEFAULT_NRD      = 2;
  localparam int DEFAULT_LINK_REG = 26;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : regfile_scoreboard
// Brief  : Pending-write scoreboard. One busy bit per register; a set
//          request marks a destination pending, a write retires it. When a
//          set and a clear hit the same bit on one edge, the set wins.
//          Bit 0 is hard-wired to not busy.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset, clears all busy bits
//   set_i      in   mark set_addr_i pending on this edge
//   set_addr_i in   register to mark pending
//   clr_i      in   one bit per register written on this edge
//   busy_o     out  registered busy vector
// ============================================================================
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = DEFAULT_NREGS,
  parameter int AW    = clog2(DEFAULT_NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_i,
  input  logic [AW-1:0]    set_addr_i,
  input  logic [NREGS-1:0] clr_i,
  output logic [NREGS-1:0] busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] w_set_vec;

  always_comb begin
    w_set_vec = '0;
    if (set_i) begin
      w_set_vec[set_addr_i] = 1'b1;
    end
    // Clear first, then OR in the set so a coincident set dominates.
    busy_d    = (busy_q & ~clr_i) | w_set_vec;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/multiport_regfile.sv
`default_nettype none
// ============================================================================
// Module : multiport_regfile
// Brief  : NREGS x DATA_W register file with NRD combinational read ports,
//          two write ports (wr1 beats wr0), a trap port that commits the
//          return address to LINK_REG over both write ports, and a
//          pending-write scoreboard. Register 0 is hard-wired to zero.
// Rev    : 1.0  initial release
// Config : define REGFILE_BYPASS_EN for same-cycle write-through forwarding
//          on rd_data and bypass-aware rd_busy; undefined, reads return
//          storage only and rd_busy is the registered busy vector.
// ----------------------------------------------------------------------------
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   rd_addr   in   NRD*AW packed read addresses, port k at [k*AW +: AW]
//   rd_data   out  NRD*DATA_W packed read data
//   rd_busy   out  busy flag of each read address
//   wr0_*     in   write port 0 (en/addr/data)
//   wr1_*     in   write port 1 (en/addr/data), wins over wr0
//   trap      in   commit trap_pc to LINK_REG this edge
//   trap_pc   in   trap return address
//   sb_set    in   mark sb_addr pending
//   sb_addr   in   register to mark pending
//   busy      out  scoreboard vector
// ============================================================================
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int  DATA_W   = DEFAULT_DATA_W,
  parameter int  NREGS    = DEFAULT_NREGS,
  parameter int  NRD      = DEFAULT_NRD,
  parameter int  LINK_REG = DEFAULT_LINK_REG,
  localparam int AW       = clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr0_en,
  input  logic [AW-1:0]         wr0_addr,
  input  logic [DATA_W-1:0]     wr0_data,
  input  logic                  wr1_en,
  input  logic [AW-1:0]         wr1_addr,
  input  logic [DATA_W-1:0]     wr1_data,
  input  logic                  trap,
  input  logic [DATA_W-1:0]     trap_pc,
  input  logic                  sb_set,
  input  logic [AW-1:0]         sb_addr,
  output logic [NREGS-1:0]      busy
);

  localparam logic [AW-1:0] LINK_ADDR = AW'(LINK_REG);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  w_wr_vec;
  logic              w_wr0;
  logic              w_wr1;
  logic              w_trap;
  logic              w_sb;

  // While reset is low nothing may write, mark pending or forward.
  assign w_wr0  = wr0_en & reset;
  assign w_wr1  = wr1_en & reset;
  assign w_trap = trap   & reset;
  assign w_sb   = sb_set & reset;

  // Next-state per register: trap > wr1 > wr0 > hold. Register 0 never
  // changes, so storage entry 0 stays at its reset value of zero.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i]   = regs_q[i];
      w_wr_vec[i] = 1'b0;
      if (i != 0) begin
        if (w_trap && (i == LINK_REG)) begin
          regs_d[i]   = trap_pc;
          w_wr_vec[i] = 1'b1;
        end else if (w_wr1 && (wr1_addr == AW'(i))) begin
          regs_d[i]   = wr1_data;
          w_wr_vec[i] = 1'b1;
        end else if (w_wr0 && (wr0_addr == AW'(i))) begin
          regs_d[i]   = wr0_data;
          w_wr_vec[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .set_i      (w_sb),
    .set_addr_i (sb_addr),
    .clr_i      (w_wr_vec),
    .busy_o     (busy)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data;
    logic              rbusy;

    assign addr = rd_addr[k*AW +: AW];

`ifdef REGFILE_BYPASS_EN
    always_comb begin
      if (addr == '0) begin
        data = '0;
      end else if (w_trap && (addr == LINK_ADDR)) begin
        data = trap_pc;
      end else if (w_wr1 && (wr1_addr == addr)) begin
        data = wr1_data;
      end else if (w_wr0 && (wr0_addr == addr)) begin
        data = wr0_data;
      end else begin
        data = regs_q[addr];
      end
    end
    // A register being written now is no longer pending for the reader.
    assign rbusy = busy[addr] & ~w_wr_vec[addr];
`else
    assign data  = (addr == '0) ? '0 : regs_q[addr];
    assign rbusy = busy[addr];
`endif

    assign rd_data[k*DATA_W +: DATA_W] = data;
    assign rd_busy[k]                  = rbusy;
  end

endmodule : multiport_regfile
`default_nettype wire

// File: tb/tb_multiport_regfile.sv
`default_nettype none
// ============================================================================
// Module : tb_multiport_regfile
// Brief  : Self-checking bench for multiport_regfile. Directed scenarios
//          plus randomized traffic checked against an array-based model.
//          A second instance uses NRD=4, DATA_W=16.
// Rev    : 1.0  initial release
// Config : honours REGFILE_BYPASS_EN for expected read/busy values.
// ============================================================================
module tb_multiport_regfile;

  localparam int DW    = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;
  localparam int LINK  = 26;
  localparam int DW2   = 16;
  localparam int NRD2  = 4;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              wr0_en, wr1_en, trap, sb_set;
  logic [AW-1:0]     wr0_addr, wr1_addr, sb_addr;
  logic [DW-1:0]     wr0_data, wr1_data, trap_pc;
  logic [NREGS-1:0]  busy;

  logic [NRD2*AW-1:0]  rd_addr_b;
  logic [NRD2*DW2-1:0] rd_data_b;
  logic [NRD2-1:0]     rd_busy_b;
  logic                wr0_en_b, wr1_en_b, trap_b, sb_set_b;
  logic [AW-1:0]       wr0_addr_b, wr1_addr_b, sb_addr_b;
  logic [DW2-1:0]      wr0_data_b, wr1_data_b, trap_pc_b;
  logic [NREGS-1:0]    busy_b;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0]    m_regs [NREGS];
  logic [NREGS-1:0] m_busy;

  always #5 clk = ~clk;

  multiport_regfile #(
    .DATA_W(DW), .NREGS(NREGS), .NRD(NRD), .LINK_REG(LINK)
  ) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr0_en(wr0_en), .wr0_addr(wr0_addr),
    .wr0_data(wr0_data), .wr1_en(wr1_en), .wr1_addr(wr1_addr),
    .wr1_data(wr1_data), .trap(trap), .trap_pc(trap_pc),
    .sb_set(sb_set), .sb_addr(sb_addr), .busy(busy)
  );

  multiport_regfile #(
    .DATA_W(DW2), .NREGS(NREGS), .NRD(NRD2), .LINK_REG(LINK)
  ) dut_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .wr0_en(wr0_en_b), .wr0_addr(wr0_addr_b),
    .wr0_data(wr0_data_b), .wr1_en(wr1_en_b), .wr1_addr(wr1_addr_b),
    .wr1_data(wr1_data_b), .trap(trap_b), .trap_pc(trap_pc_b),
    .sb_set(sb_set_b), .sb_addr(sb_addr_b), .busy(busy_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_written(input logic [AW-1:0] a);
    if (!reset || a == '0) return 1'b0;
    return (trap && a == AW'(LINK)) || (wr1_en && a == wr1_addr) || (wr0_en && a == wr0_addr);
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == '0) return '0;
    if (BYP && reset) begin
      if (trap && a == AW'(LINK)) return trap_pc;
      if (wr1_en && a == wr1_addr) return wr1_data;
      if (wr0_en && a == wr0_addr) return wr0_data;
    end
    return m_regs[a];
  endfunction

  function automatic logic m_rbusy(input logic [AW-1:0] a);
    if (BYP && m_written(a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_busy = '0;
  endtask

  // Apply writes lowest priority first so higher priority overwrites.
  task automatic m_edge();
    if (!reset) return;
    if (wr0_en && wr0_addr != '0) begin m_regs[wr0_addr] = wr0_data; m_busy[wr0_addr] = 1'b0; end
    if (wr1_en && wr1_addr != '0) begin m_regs[wr1_addr] = wr1_data; m_busy[wr1_addr] = 1'b0; end
    if (trap) begin m_regs[LINK] = trap_pc; m_busy[LINK] = 1'b0; end
    if (sb_set && sb_addr != '0) m_busy[sb_addr] = 1'b1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_idle();
    wr0_en = 0; wr1_en = 0; trap = 0; sb_set = 0;
    wr0_addr = '0; wr1_addr = '0; sb_addr = '0;
    wr0_data = '0; wr1_data = '0; trap_pc = '0;
  endtask

  task automatic set_idle_b();
    wr0_en_b = 0; wr1_en_b = 0; trap_b = 0; sb_set_b = 0;
    wr0_addr_b = '0; wr1_addr_b = '0; sb_addr_b = '0;
    wr0_data_b = '0; wr1_data_b = '0; trap_pc_b = '0;
    rd_addr_b = '0;
  endtask

  task automatic check_reads();
    logic [AW-1:0] a;
    for (int k = 0; k < NRD; k++) begin
      a = rd_addr[k*AW +: AW];
      check_eq($sformatf("rd_data%0d@%0d", k, a), 64'(rd_data[k*DW +: DW]), 64'(m_read(a)));
      check_eq($sformatf("rd_busy%0d@%0d", k, a), 64'(rd_busy[k]), 64'(m_rbusy(a)));
    end
  endtask

  // Inputs are set at posedge+1; check reads mid-cycle, clock, check busy.
  task automatic tick();
    #1;
    check_reads();
    @(posedge clk);
    m_edge();
    #1;
    check_eq("busy_vec", 64'(busy), 64'(m_busy));
    set_idle();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 8) return AW'(LINK);
    if (r == 9) return AW'($urandom_range(0, NREGS-1));
    return AW'(r);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    rd_addr = '0;
    set_idle();
    set_idle_b();
    m_reset();
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;

    // Preload every register and mark all pending.
    for (int i = 1; i < NREGS; i++) begin
      wr0_en = 1; wr0_addr = AW'(i); wr0_data = 32'h1000 + i;
      sb_set = 1; sb_addr = AW'(i);
      tick();
    end
    rd_addr = {AW'(26), AW'(5)};
    #1;
    check_eq("preload_r5", 64'(rd_data[0 +: DW]), 64'h1005);
    check_eq("preload_busy", 64'(busy), 64'hFFFF_FFFE);

    // Mid-cycle reset with a write pending.
    wr1_en = 1; wr1_addr = 5'd9; wr1_data = 32'hBEEF; sb_set = 1; sb_addr = 5'd9;
    #1 reset = 1'b0;
    #1;
    m_reset();
    check_eq("rst_rd0", 64'(rd_data[0 +: DW]), 64'h0);
    check_eq("rst_rd1", 64'(rd_data[DW +: DW]), 64'h0);
    check_eq("rst_busy", 64'(busy), 64'h0);
    @(posedge clk); #1;
    rd_addr = {AW'(9), AW'(5)};
    #1;
    check_eq("rst_hold_r9", 64'(rd_data[DW +: DW]), 64'h0);
    check_eq("rst_hold_busy", 64'(busy), 64'h0);
    set_idle();
    #1 reset = 1'b1;
    @(posedge clk); #1;
    wr0_en = 1; wr0_addr = 5'd4; wr0_data = 32'h44;
    tick();
    rd_addr = {AW'(9), AW'(4)};
    #1;
    check_eq("post_rst_r4", 64'(rd_data[0 +: DW]), 64'h44);
    check_eq("post_rst_r9", 64'(rd_data[DW +: DW]), 64'h0);
    tick();

    // wr1 beats wr0 on the same address.
    wr0_en = 1; wr0_addr = 5'd5; wr0_data = 32'h11;
    wr1_en = 1; wr1_addr = 5'd5; wr1_data = 32'h22;
    tick();
    rd_addr = {AW'(0), AW'(5)};
    #1 check_eq("wr1_wins", 64'(rd_data[0 +: DW]), 64'h22);
    tick();

    // Same-cycle write and read of address 3.
    wr0_en = 1; wr0_addr = 5'd3; wr0_data = 32'h1234;
    tick();
    wr0_en = 1; wr0_addr = 5'd3; wr0_data = 32'hDEAD; rd_addr = {AW'(0), AW'(3)};
    #1 check_eq("bypass_r3", 64'(rd_data[0 +: DW]), BYP ? 64'hDEAD : 64'h1234);
    tick();
    #1 check_eq("after_r3", 64'(rd_data[0 +: DW]), 64'hDEAD);

    // Trap overrides wr1 to LINK_REG and clears its busy bit.
    sb_set = 1; sb_addr = AW'(LINK);
    tick();
    check_eq("link_busy_set", 64'(busy[LINK]), 64'h1);
    trap = 1; trap_pc = 32'h400; wr1_en = 1; wr1_addr = AW'(LINK); wr1_data = 32'h55;
    rd_addr = {AW'(LINK), AW'(0)};
    tick();
    #1;
    check_eq("trap_r26", 64'(rd_data[DW +: DW]), 64'h400);
    check_eq("trap_busy26", 64'(busy[LINK]), 64'h0);

    // Set beats clear on the same edge; a later write clears.
    sb_set = 1; sb_addr = 5'd7;
    tick();
    sb_set = 1; sb_addr = 5'd7; wr0_en = 1; wr0_addr = 5'd7; wr0_data = 32'h77;
    tick();
    check_eq("set_wins_b7", 64'(busy[7]), 64'h1);
    wr0_en = 1; wr0_addr = 5'd7; wr0_data = 32'h78;
    tick();
    check_eq("clear_b7", 64'(busy[7]), 64'h0);

    // Writes and set to register 0 have no effect.
    wr0_en = 1; wr0_addr = '0; wr0_data = 32'hFFFF_FFFF;
    wr1_en = 1; wr1_addr = '0; wr1_data = 32'hAAAA_AAAA;
    sb_set = 1; sb_addr = '0; rd_addr = '0;
    #1;
    check_eq("r0_same_cycle", 64'(rd_data), 64'h0);
    tick();
    check_eq("r0_after", 64'(rd_data), 64'h0);
    check_eq("r0_busy", 64'(busy[0]), 64'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      wr0_en = 1'($urandom_range(0, 1)); wr0_addr = rand_addr(); wr0_data = $urandom;
      wr1_en = 1'($urandom_range(0, 1)); wr1_addr = rand_addr(); wr1_data = $urandom;
      trap = ($urandom_range(0, 7) == 0); trap_pc = $urandom;
      sb_set = 1'($urandom_range(0, 1)); sb_addr = rand_addr();
      rd_addr = {rand_addr(), rand_addr()};
      tick();
    end

    // Second instance: NRD=4, DATA_W=16.
    wr0_en_b = 1; wr0_addr_b = '0; wr0_data_b = 16'hFFFF;
    wr1_en_b = 1; wr1_addr_b = 5'd1; wr1_data_b = 16'hA5A5;
    sb_set_b = 1; sb_addr_b = '0;
    rd_addr_b = {AW'(3), AW'(2), AW'(1), AW'(0)};
    #1;
    check_eq("b_p0_r0", 64'(rd_data_b[0 +: DW2]), 64'h0);
    check_eq("b_p1_r1", 64'(rd_data_b[DW2 +: DW2]), BYP ? 64'hA5A5 : 64'h0);
    check_eq("b_rd_busy", 64'(rd_busy_b), 64'h0);
    @(posedge clk); #1;
    check_eq("b_busy0", 64'(busy_b), 64'h0);
    wr0_en_b = 1; wr0_addr_b = 5'd2; wr0_data_b = 16'h1234;
    wr1_en_b = 1; wr1_addr_b = '0; wr1_data_b = 16'h7777;
    sb_set_b = 1; sb_addr_b = 5'd3;
    #1;
    check_eq("b_p0_r0w", 64'(rd_data_b[0 +: DW2]), 64'h0);
    check_eq("b_p1_r1", 64'(rd_data_b[DW2 +: DW2]), 64'hA5A5);
    check_eq("b_p2_r2", 64'(rd_data_b[2*DW2 +: DW2]), BYP ? 64'h1234 : 64'h0);
    @(posedge clk); #1;
    set_idle_b();
    rd_addr_b = {AW'(3), AW'(2), AW'(1), AW'(0)};
    #1;
    check_eq("b_busy3", 64'(busy_b), 64'h8);
    check_eq("b_rd_busy3", 64'(rd_busy_b), 64'h8);
    check_eq("b_p2_after", 64'(rd_data_b[2*DW2 +: DW2]), 64'h1234);
    check_eq("b_p3_after", 64'(rd_data_b[3*DW2 +: DW2]), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_multiport_regfile
`default_nettype wire
